// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared types and default widths for the data-memory arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2
    } owner_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
// ============================================================================
// Module : rr_pick2
// Brief  : Two-way round-robin pick with locked-owner override.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  owner_t     owner,
    input  logic       hold_expired,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (owner == P0 && req[0] && (!req[1] || !hold_expired)) begin
            gnt = 2'b01;
        end else if (owner == P1 && req[1] && (!req[0] || !hold_expired)) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
            // A requesting owner reaching here has exhausted its hold: hand over.
            if (owner == P0)      gnt = 2'b10;
            else if (owner == P1) gnt = 2'b01;
            else                  gnt = prio ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module : dmem_arbiter
// Brief  : Round-robin, lockable arbiter for the shared single-port data memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_t            owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]        gnt_w;
    logic              hold_expired_w;

    assign hold_expired_w = (hold_cnt_q >= 8'(MAX_HOLD));

    rr_pick2 u_pick (
        .req          ({req1, req0}),
        .prio         (prio_q),
        .owner        (owner_q),
        .hold_expired (hold_expired_w),
        .gnt          (gnt_w)
    );

    assign gnt0 = gnt_w[0];
    assign gnt1 = gnt_w[1];

    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_w[0]) begin
            mem_re    = ~we0;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt_w[1]) begin
            mem_re    = ~we1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_comb begin
        owner_d    = NONE;
        prio_d     = prio_q;
        hold_cnt_d = 8'd0;
        if (gnt_w[0]) begin
            prio_d     = 1'b1;
            owner_d    = lock0 ? P0 : NONE;
            hold_cnt_d = (owner_q == P0) ? sat_inc8(hold_cnt_q) : 8'd1;
        end else if (gnt_w[1]) begin
            prio_d     = 1'b0;
            owner_d    = lock1 ? P1 : NONE;
            hold_cnt_d = (owner_q == P1) ? sat_inc8(hold_cnt_q) : 8'd1;
        end
    end

    // Read data is captured one edge after the grant; rdata holds otherwise.
    always_comb begin
        rvalid0_d = gnt_w[0] & ~we0;
        rvalid1_d = gnt_w[1] & ~we1;
        rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= NONE;
            prio_q     <= 1'b0;
            hold_cnt_q <= 8'd0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Directed and random checks of dmem_arbiter against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
    import mem_pkg::*;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_re, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    // Memory: unwritten words read back as (aligned address + 1).
    logic [31:0] tb_mem [64];
    logic [63:0] tb_wr = '0;
    assign mem_rdata = tb_wr[mem_addr[7:2]] ? tb_mem[mem_addr[7:2]]
                                            : {mem_addr[31:2], 2'b00} + 32'd1;
    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr[7:2]] <= mem_wdata;
            tb_wr[mem_addr[7:2]]  <= 1'b1;
        end
    end

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Reference model state: owner -1 = none, else port index.
    int          m_owner, m_prio, m_hold;
    logic [1:0]  m_rv;
    logic [31:0] m_rd [2];
    logic [31:0] m_mem [64];
    logic [63:0] m_wr = '0;
    int          checks = 0, errors = 0;
    logic        s_g0, s_g1, s_we;
    logic [31:0] s_addr, s_wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_prio = 0; m_hold = 0; m_rv = 2'b00;
        m_rd[0] = 32'd0; m_rd[1] = 32'd0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return m_wr[a[7:2]] ? m_mem[a[7:2]] : {a[31:2], 2'b00} + 32'd1;
    endfunction

    function automatic int pick();
        logic r [2];
        r[0] = req0; r[1] = req1;
        if (m_owner >= 0 && r[m_owner] && (!r[1-m_owner] || m_hold < MAX_HOLD)) return m_owner;
        if (r[0] && r[1]) return (m_owner >= 0) ? 1 - m_owner : m_prio;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    // One clock cycle: check all outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        int g;
        logic [31:0] ea, ewd;
        logic ere, ewe;
        @(negedge clk);
        g = pick();
        ea = 0; ewd = 0; ere = 0; ewe = 0;
        if (g == 0) begin ea = addr0; ewd = wdata0; ewe = we0; ere = !we0; end
        if (g == 1) begin ea = addr1; ewd = wdata1; ewe = we1; ere = !we1; end
        chk("gnt0", gnt0, g == 0);
        chk("gnt1", gnt1, g == 1);
        chk("mem_re", mem_re, ere);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ewd);
        chk("rvalid0", rvalid0, m_rv[0]);
        chk("rvalid1", rvalid1, m_rv[1]);
        chk("rdata0", rdata0, m_rd[0]);
        chk("rdata1", rdata1, m_rd[1]);
        s_g0 = gnt0; s_g1 = gnt1; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (g >= 0) begin
            m_rv = 2'b00;
            if (!ewe) begin
                m_rv[g] = 1'b1;
                m_rd[g] = m_read(ea);
            end else begin
                m_mem[ea[7:2]] = ewd;
                m_wr[ea[7:2]]  = 1'b1;
            end
            m_hold  = (m_owner == g) ? ((m_hold < 255) ? m_hold + 1 : 255) : 1;
            m_owner = ((g == 0) ? lock0 : lock1) ? g : -1;
            m_prio  = 1 - g;
        end else begin
            m_rv = 2'b00; m_owner = -1; m_hold = 0;
        end
        #1;
    endtask

    initial begin
        model_reset();
        // Reset
        tick(); tick();
        chk("rst_owner", dut.owner_q, NONE);
        chk("rst_prio", dut.prio_q, 1'b0);
        chk("rst_hold", dut.hold_cnt_q, 8'd0);
        rst = 1'b1;

        // Contended reads alternate starting with P0
        req0 = 1; we0 = 0; addr0 = 32'h10;
        req1 = 1; we1 = 0; addr1 = 32'h20;
        tick(); chk("tp1_c0_gnt0", s_g0, 1'b1);
        tick(); chk("tp1_c1_gnt1", s_g1, 1'b1);
        chk("tp1_rdata0", rdata0, 32'h11);
        chk("tp1_rvalid1", rvalid1, 1'b1);
        chk("tp1_rdata1", rdata1, 32'h21);
        tick(); chk("tp1_c2_gnt0", s_g0, 1'b1);
        tick(); chk("tp1_c3_gnt1", s_g1, 1'b1);

        // Idle
        req0 = 0; req1 = 0;
        tick(); chk("idle_gnt", {s_g1, s_g0}, 2'b00);

        // Lone write from P1
        req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'hDEADBEEF;
        tick();
        chk("wr_gnt1", s_g1, 1'b1);
        chk("wr_we", s_we, 1'b1);
        chk("wr_addr", s_addr, 32'h40);
        chk("wr_wdata", s_wd, 32'hDEADBEEF);
        req1 = 0; we1 = 0;
        chk("wr_norv", rvalid1, 1'b0);
        req0 = 1; we0 = 0; addr0 = 32'h40;
        tick(); req0 = 0;
        tick(); chk("wr_readback", rdata0, 32'hDEADBEEF);

        // Locked burst with bounded hold
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 32'h08;
        tick(); chk("lk_c0", s_g0, 1'b1);
        req1 = 1; we1 = 0; addr1 = 32'h0C;
        for (int c = 1; c < 4; c++) begin
            tick(); chk("lk_p0", s_g0, 1'b1);
        end
        tick(); chk("lk_c4_release", s_g1, 1'b1);
        tick(); chk("lk_c5_p0", s_g0, 1'b1);
        req1 = 0;

        // Long uncontended burst saturates the counter
        for (int c = 0; c < 300; c++) tick();
        chk("sat_hold", dut.hold_cnt_q, 8'd255);
        chk("sat_gnt0", s_g0, 1'b1);
        req0 = 0; lock0 = 0;
        tick();

        // Reset during a locked P1 read burst
        req1 = 1; we1 = 0; lock1 = 1; addr1 = 32'h30;
        tick(); tick();
        @(negedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rstmid_rvalid1", rvalid1, 1'b0);
        chk("rstmid_owner", dut.owner_q, NONE);
        chk("rstmid_prio", dut.prio_q, 1'b0);
        chk("rstmid_hold", dut.hold_cnt_q, 8'd0);
        @(posedge clk); #1;
        tick();
        rst = 1'b1;
        req0 = 1; we0 = 0; addr0 = 32'h34; lock1 = 0;
        tick(); chk("rstmid_p0_first", s_g0, 1'b1);
        req0 = 0; req1 = 0;
        tick();

        // Random traffic; ungranted requests stay stable
        for (int c = 0; c < 400; c++) begin
            if (!req0 || s_g0) begin
                req0   = ($urandom_range(0, 99) < 60);
                we0    = $urandom_range(0, 1);
                addr0  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                wdata0 = $urandom;
            end
            if (!req1 || s_g1) begin
                req1   = ($urandom_range(0, 99) < 60);
                we1    = $urandom_range(0, 1);
                addr1  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                wdata1 = $urandom;
            end
            lock0 = ($urandom_range(0, 3) != 0);
            lock1 = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
